// File: rtl/sim_uart_rx_ctrl.sv
// sim_uart_rx_ctrl -- sequencing controller for the UART receiver VIP.
//
// Generates the receiver's clken tick, owns its baud scaler register, runs the
// rdy/rdy_clr handshake and queues received bytes in a FIFO for a bench
// consumer. Flags FIFO overruns and pulses o_idle when the line has been quiet
// for IDLE_BITS bit periods after the last byte.
//
// Ports:
//   clk_50m, rst          clock (rising edge), async active-high reset
//   cfg_wr, cfg_scaler    scaler write (0 is stored as 1)
//   scaler, clken         to the receiver: baud scaler and sample-enable tick
//   rx_rdy, rx_data       from the receiver: byte ready and byte value
//   rdy_clr               to the receiver: one-cycle clear strobe per byte
//   o_valid, o_data       FIFO head (decoded from the pointers)
//   i_ready               consumer pop, effective when o_valid is high
//   o_count               bytes held (decoded from the pointers)
//   o_ovr, ovr_cnt        sticky overrun flag, saturating dropped-byte count
//   ovr_clr               clears o_ovr and ovr_cnt (an overflow in the same
//                         cycle wins)
//   o_idle                one-cycle end-of-burst pulse
//
// Optional: define SIM_UART_RX_CTRL_LOG_EN to print captured bytes as text
// lines (simulation only); logic behaviour is unchanged.

module sim_uart_rx_ctrl #(
  parameter int CLKEN_DIV      = 1,
  parameter int SCALER_DEFAULT = 8,
  parameter int FIFO_ABITS     = 4,
  parameter int IDLE_BITS      = 10
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [31:0]         cfg_scaler,
  output logic [31:0]         scaler,
  output logic                clken,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  output logic                rdy_clr,
  output logic                o_valid,
  output logic [7:0]          o_data,
  input  logic                i_ready,
  output logic [FIFO_ABITS:0] o_count,
  output logic                o_ovr,
  input  logic                ovr_clr,
  output logic [7:0]          ovr_cnt,
  output logic                o_idle
);

  localparam int DEPTH = 1 << FIFO_ABITS;
  localparam int PW    = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
  localparam int BPW   = $clog2(IDLE_BITS + 1);

  typedef enum logic {S_WAIT, S_CLR} state_t;

  state_t                state, state_nxt;
  logic                  capture;
  logic [PW-1:0]         psc, psc_nxt;
  logic [7:0]            mem [DEPTH];
  logic [FIFO_ABITS:0]   wptr, rptr;
  logic                  full, pop, push_ok, drop;
  logic [32:0]           bt;
  logic [32:0]           bit_len;
  logic                  bt_wrap;
  logic [BPW-1:0]        bp;
  logic                  armed;

  // Prescaler: clken is registered, so it is asserted for the cycle in which
  // the count sits at CLKEN_DIV-1.
  always_comb psc_nxt = (psc == PW'(CLKEN_DIV - 1)) ? '0 : psc + 1'b1;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      psc   <= '0;
      clken <= 1'b0;
    end else begin
      psc   <= psc_nxt;
      clken <= (psc_nxt == PW'(CLKEN_DIV - 1));
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)         scaler <= 32'(SCALER_DEFAULT);
    else if (cfg_wr) scaler <= (cfg_scaler == 32'd0) ? 32'd1 : cfg_scaler;
  end

  // Handshake FSM. S_CLR lasts exactly one cycle, which covers the receiver
  // dropping rdy on the edge after rdy_clr.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_WAIT: if (rx_rdy) begin
        capture   = 1'b1;
        state_nxt = S_CLR;
      end
      S_CLR:   state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) rdy_clr <= 1'b0;
    else     rdy_clr <= capture;
  end

  // FIFO: one extra pointer bit distinguishes full from empty.
  assign o_count = wptr - rptr;
  assign o_valid = (wptr != rptr);
  assign o_data  = mem[rptr[FIFO_ABITS-1:0]];
  assign full    = (o_count == (FIFO_ABITS + 1)'(DEPTH));
  assign pop     = o_valid & i_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok = capture & (~full | pop);
  assign drop    = capture & ~push_ok;

  always_ff @(posedge clk_50m) begin
    if (push_ok) mem[wptr[FIFO_ABITS-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      o_ovr   <= 1'b0;
      ovr_cnt <= 8'd0;
    end else if (drop) begin
      o_ovr   <= 1'b1;
      ovr_cnt <= ovr_clr ? 8'd1 : ((ovr_cnt == 8'hFF) ? ovr_cnt : ovr_cnt + 8'd1);
    end else if (ovr_clr) begin
      o_ovr   <= 1'b0;
      ovr_cnt <= 8'd0;
    end
  end

  // Idle detect: bit timer spans 2*scaler clken ticks (33 bits so a full-range
  // scaler cannot overflow); bp counts completed bit periods since the last byte.
  assign bit_len = {scaler, 1'b0};
  assign bt_wrap = clken && (bt == bit_len - 33'd1);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      bt     <= '0;
      bp     <= '0;
      armed  <= 1'b0;
      o_idle <= 1'b0;
    end else begin
      o_idle <= 1'b0;
      if (capture) begin
        bt    <= '0;
        bp    <= '0;
        armed <= 1'b1;
      end else begin
        if (cfg_wr)     bt <= '0;
        else if (clken) bt <= bt_wrap ? '0 : bt + 33'd1;
        if (armed && bt_wrap && !cfg_wr) begin
          if (bp == BPW'(IDLE_BITS - 1)) begin
            o_idle <= 1'b1;
            armed  <= 1'b0;
            bp     <= '0;
          end else begin
            bp <= bp + 1'b1;
          end
        end
      end
    end
  end

`ifdef SIM_UART_RX_CTRL_LOG_EN
  // Text logger; every captured byte is logged, including dropped ones.
  string line_buf = "";
  always @(posedge clk_50m) begin
    if (!rst) begin
      if (o_idle && line_buf.len() > 0) begin
        $display("%0t: %s", $time, line_buf);
        line_buf = "";
      end
      if (capture) begin
        if (rx_data == 8'h0A) begin
          $display("%0t: %s", $time, line_buf);
          line_buf = "";
        end else if (rx_data != 8'h0D) begin
          line_buf = $sformatf("%s%c", line_buf, rx_data);
          if (line_buf.len() >= 80) begin
            $display("%0t: %s", $time, line_buf);
            line_buf = "";
          end
        end
      end
    end
  end
`else
`endif

endmodule

// File: doc/sim_uart_rx_ctrl.md
Name: sim_uart_rx_ctrl

Overview:
- Simulation VIP controller that sequences the UART receiver VIP. It generates the receiver's clken tick and owns its baud scaler register.
- Runs the rdy/rdy_clr handshake and buffers received bytes in a FIFO for a testbench consumer.
- Reports FIFO overrun and line-idle (end-of-burst) events.
- Sits between the receiver instance and the bench's checker/logger.

Parameters:
- CLKEN_DIV, 1, clken period in clk_50m cycles (1 = clken held high).
- SCALER_DEFAULT, 8, reset value of the scaler register. One bit period = 2*scaler clken ticks.
- FIFO_ABITS, 4, FIFO depth = 2**FIFO_ABITS bytes.
- IDLE_BITS, 10, bit periods of silence after the last byte before the idle pulse fires.

Ports:
- clk_50m  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_wr  in  1  scaler write strobe.
- cfg_scaler  in  32  new scaler value.
- scaler  out  32  scaler to the receiver.
- clken  out  1  sample-enable tick to the receiver.
- rx_rdy  in  1  receiver byte-ready.
- rx_data  in  8  receiver byte.
- rdy_clr  out  1  clear strobe to the receiver.
- o_valid  out  1  FIFO not empty.
- o_data  out  8  FIFO head byte.
- i_ready  in  1  consumer pop (pop = o_valid & i_ready).
- o_count  out  FIFO_ABITS+1  bytes held.
- o_ovr  out  1  sticky overrun flag.
- ovr_clr  in  1  clears o_ovr and ovr_cnt.
- ovr_cnt  out  8  dropped-byte counter, saturates at 255.
- o_idle  out  1  one-cycle idle pulse.

Behaviour:
- Reset (async, immediate): scaler=SCALER_DEFAULT; clken=0; rdy_clr=0; FIFO empty (o_valid=0, o_count=0); o_ovr=0; ovr_cnt=0; o_idle=0; FSM=S_WAIT; prescaler, bit timer and idle counters=0; idle disarmed.
- All outputs are registered except o_valid, o_data and o_count, which are decoded from the FIFO pointers.
- Reset asserted mid-handshake:
  - The FIFO is flushed.
  - Any pending rdy_clr is dropped.
  - A byte still flagged by the receiver after reset is captured normally.
- Prescaler:
  - Counts 0..CLKEN_DIV-1; clken=1 in the cycle the count is CLKEN_DIV-1.
  - CLKEN_DIV=1 gives clken=1 on every cycle from the first edge after reset.
- Scaler:
  - cfg_wr updates scaler on the next edge.
  - A written value of 0 is stored as 1.
  - The bit timer restarts at 0 on a write.
- Handshake FSM:
  - S_WAIT: on rx_rdy=1, capture rx_data, push it into the FIFO, rdy_clr<=1, go to S_CLR.
  - S_CLR: rdy_clr<=0, go to S_WAIT.
  - rdy_clr is high exactly one cycle per byte.
  - Detect-to-rdy_clr latency: 1 cycle.
  - The receiver drops rdy on the edge after rdy_clr, so S_WAIT never re-captures the same byte.
  - rx_rdy is ignored in S_CLR.
- FIFO:
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - When accepted with a simultaneous pop, the count is unchanged.
  - Otherwise the byte is dropped: o_ovr<=1 and ovr_cnt increments, saturating at 255.
  - Pop when empty is ignored.
  - Pointers wrap modulo depth.
  - If ovr_clr coincides with an overflow, the overflow wins: o_ovr=1 and ovr_cnt=1.
- Idle detect:
  - Bit timer counts clken ticks 0..2*scaler-1; a wrap ends one bit period, and 2*scaler is computed in 33 bits.
  - Each captured byte rearms idle and zeroes the bit timer and the bit-period counter.
  - When the bit-period counter reaches IDLE_BITS while armed, o_idle=1 for one cycle and idle disarms.
  - No further idle pulses occur until the next byte.
  - After reset, idle stays disarmed until the first byte.

Optional Feature:
- Macro: SIM_UART_RX_CTRL_LOG_EN.
- Defined:
  - Each captured byte is appended to an 80-character line buffer.
  - On 8'h0A, on a full buffer, or on o_idle with a non-empty buffer, the block prints the line via $display with the $time prefix, then clears the buffer.
  - 8'h0D is discarded.
  - Dropped (overrun) bytes are still logged.
- Undefined: no logging code; RTL behaviour is identical.

Test Plan:
- Reset, CLKEN_DIV=1, SCALER_DEFAULT=8, receiver attached, 0x55 sent at 16 clocks/bit: o_data=0x55, o_valid=1, rdy_clr high exactly one cycle, one cycle after rx_rdy rises.
- CLKEN_DIV=4: clken high 1 cycle in every 4. cfg_wr with cfg_scaler=0: scaler reads 1.
- Push 17 bytes with i_ready=0 and FIFO_ABITS=4: o_count=16, o_ovr=1, ovr_cnt=1. Then pop all: bytes 0..15 come out in order.
- FIFO full, byte arrives in the same cycle as a pop: no overrun, o_count stays 16.
- Burst of 3 bytes then silence, scaler=8, CLKEN_DIV=1: o_idle pulses once, 160 cycles after the third rdy_clr. No second pulse.
- Assert rst while in S_CLR with 5 bytes queued: rdy_clr=0, o_count=0 immediately. The next received byte is delivered normally.
